led_count_allocator: RTL

Upstream partner of the LED serializer. It converts the per-bin note amplitudes of one analysis frame into per-bin LED counts that sum to exactly `LEDS`. The count array and a one-cycle `data_v` strobe feed the serializer's `LEDCounts` and `start` inputs. Computation is fully sequential: one shared accumulator and one restoring divider, iterated over the bins.

---
 rtl/led_count_allocator.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/led_count_allocator.sv
// led_count_allocator
//
// Splits a fixed budget of LEDS LEDs across BIN_QTY note bins in
// proportion to each bin's amplitude. Each bin gets
// floor(amp*LEDS/total) LEDs. The rounding shortfall is then added to
// the lowest-index bin that holds the largest amplitude, so the counts
// always sum to exactly LEDS. A zero total produces all-zero counts.
//
// The datapath is one accumulator plus one restoring divider. The divider
// produces one quotient bit per cycle, and both are reused across the bins.
//
// Ports
//   clk        system clock
//   rst        asynchronous, active-high reset
//   amplitudes [BIN_QTY-1:0][AW-1:0] bin amplitudes, sampled on the accepting edge
//   start      request an allocation; honoured only while idle
//   LEDCounts  [BIN_QTY-1:0][$clog2(LEDS)-1:0] registered result, held until the next result
//   data_v     one-cycle strobe while LEDCounts shows a fresh result
//   busy       high whenever a computation is in progress
//
// LEDS must not be a power of two. This lets a count of LEDS fit in
// $clog2(LEDS) bits.

module led_count_allocator #(
  parameter int LEDS      = 50,
  parameter int BIN_QTY   = 12,
  parameter int AW        = 16,
  parameter int AMP_FLOOR = 0
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [BIN_QTY-1:0][AW-1:0]            amplitudes,
  input  logic                                  start,
  output logic [BIN_QTY-1:0][$clog2(LEDS)-1:0]  LEDCounts,
  output logic                                  data_v,
  output logic                                  busy
);

  localparam int QW = $clog2(LEDS + 1);                    // quotient bits per bin
  localparam int CW = $clog2(LEDS);                        // stored count bits
  localparam int TW = AW + $clog2(BIN_QTY);                // exact total width
  localparam int IW = (BIN_QTY > 1) ? $clog2(BIN_QTY) : 1; // bin index width
  localparam int BW = (QW > 1) ? $clog2(QW) : 1;           // divider step counter
  localparam int PW = AW + QW;                             // amp*LEDS width
  localparam int DW = TW + QW;                             // shifted-divisor width

  typedef enum logic [2:0] {S_IDLE, S_SUM, S_DIV, S_REM, S_DONE} state_t;

  state_t                     r_state, w_next;
  logic [BIN_QTY-1:0][AW-1:0] r_amp;
  logic [BIN_QTY-1:0][CW-1:0] r_count;
  logic [TW-1:0]              r_total;
  logic [QW-1:0]              r_alloc;
  logic [IW-1:0]              r_idx;
  logic [IW-1:0]              r_argmax;
  logic [BW-1:0]              r_bit;
  logic [PW-1:0]              r_rem;
  logic [QW-1:0]              r_quo;

  logic          w_last_bin;
  logic          w_last_bit;
  logic [TW-1:0] w_total_sum;
  logic [PW-1:0] w_prod;
  logic [PW-1:0] w_rem_cur;
  logic [QW-1:0] w_quo_base;
  logic [BW-1:0] w_shift;
  logic [DW-1:0] w_den;
  logic          w_fit;
  logic [QW-1:0] w_quo_next;
  logic [PW-1:0] w_rem_next;
  logic [QW-1:0] w_leftover;

  // ---------------------------------------------------------------------------
  // Shared arithmetic
  // ---------------------------------------------------------------------------
  assign w_last_bin  = (r_idx == IW'(BIN_QTY - 1));
  assign w_last_bit  = (r_bit == BW'(QW - 1));
  assign w_total_sum = r_total + TW'(r_amp[r_idx]);
  assign w_prod      = PW'(r_amp[r_idx]) * PW'(LEDS);

  // The first step of every bin takes a fresh dividend and an empty quotient.
  // Later steps continue from the registered partial remainder.
  assign w_rem_cur  = (r_bit == '0) ? w_prod : r_rem;
  assign w_quo_base = (r_bit == '0) ? '0 : r_quo;

  // The quotient never exceeds LEDS < 2^QW, so QW trial subtractions of
  // total<<k (k = QW-1 down to 0) give the exact floor quotient.
  assign w_shift    = BW'(QW - 1) - r_bit;
  assign w_den      = DW'(r_total) << w_shift;
  assign w_fit      = (DW'(w_rem_cur) >= w_den);
  assign w_rem_next = w_fit ? PW'(DW'(w_rem_cur) - w_den) : w_rem_cur;
  assign w_quo_next = (w_quo_base << 1) | QW'(w_fit);

  assign w_leftover = QW'(LEDS) - r_alloc;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: every clocked process uses non-blocking assignments. All registers
  // then update together from the values they held before the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  // NOTE: w_next is given a default before the case. Every path then assigns
  // it, so no latch can be inferred.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: if (start) w_next = S_SUM;
      // A zero total skips the divider. It goes through REM, which loads
      // zero counts, so both outcomes take the same REM -> DONE path.
      S_SUM:  if (w_last_bin) w_next = (w_total_sum == '0) ? S_REM : S_DIV;
      S_DIV:  if (w_last_bit && w_last_bin) w_next = S_REM;
      S_REM:  w_next = S_DONE;
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    busy   = (r_state != S_IDLE);
    data_v = (r_state == S_DONE);
  end

  // ---------------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------------
  // NOTE: the amplitude and count arrays are reset like any other register.
  // After reset the state is then fully defined, and a reset in the middle
  // of a computation leaves nothing stale behind.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_amp     <= '0;
      r_count   <= '0;
      r_total   <= '0;
      r_alloc   <= '0;
      r_idx     <= '0;
      r_argmax  <= '0;
      r_bit     <= '0;
      r_rem     <= '0;
      r_quo     <= '0;
      LEDCounts <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            for (int b = 0; b < BIN_QTY; b++)
              r_amp[b] <= (amplitudes[b] > AW'(AMP_FLOOR)) ? amplitudes[b] : '0;
            r_total  <= '0;
            r_alloc  <= '0;
            r_argmax <= '0;
            r_idx    <= '0;
            r_bit    <= '0;
          end
        end

        S_SUM: begin
          r_total <= w_total_sum;
          // A strict compare keeps the lowest index when amplitudes tie.
          if (r_amp[r_idx] > r_amp[r_argmax]) r_argmax <= r_idx;
          r_idx <= w_last_bin ? '0 : r_idx + 1'b1;
          r_bit <= '0;
        end

        S_DIV: begin
          r_rem <= w_rem_next;
          r_quo <= w_quo_next;
          if (w_last_bit) begin
            r_count[r_idx] <= CW'(w_quo_next);
            r_alloc        <= r_alloc + w_quo_next;
            r_bit          <= '0;
            r_idx          <= w_last_bin ? '0 : r_idx + 1'b1;
          end else begin
            r_bit <= r_bit + 1'b1;
          end
        end

        S_REM: begin
          for (int b = 0; b < BIN_QTY; b++) begin
            if (r_total == '0)
              LEDCounts[b] <= '0;
            else if (IW'(b) == r_argmax)
              LEDCounts[b] <= r_count[b] + CW'(w_leftover);
            else
              LEDCounts[b] <= r_count[b];
          end
        end

        S_DONE: ;

        default: ;
      endcase
    end
  end

endmodule
